glip_uart_receive_cfg: RTL and testbench

Parametrised next-generation UART receiver for the GLIP UART backend. It replaces the fixed 8N1 receiver with these generalisations:
- configurable data width, parity and stop bits;
- a run-time baud divisor;
- per-byte frame and parity error flags;
- break detection;
- an internal first-word-fall-through (FWFT) buffer with ready/valid backpressure.

It sits in the clk_io domain between the uart_rx pin and the control block's ingress path.

---
 rtl/glip_uart_receive_cfg_if.sv | 32 +++
 rtl/glip_uart_receive_cfg.sv | 243 ++++++++++++++++++++++++
 tb/tb_glip_uart_receive_cfg.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/glip_uart_receive_cfg_if.sv
// glip_uart_receive_cfg_if: head-of-buffer handshake of the configurable UART receiver.
//   out_data       : head entry data (DATA_BITS wide)
//   out_parity_err : head entry had a parity mismatch
//   out_frame_err  : head entry had a low stop bit
//   out_valid      : buffer non-empty
//   out_ready      : consumer accepts the head entry
// Modports: master = receiver side, slave = consumer side.
interface glip_uart_receive_cfg_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] out_data;
   logic                 out_parity_err;
   logic                 out_frame_err;
   logic                 out_valid;
   logic                 out_ready;

   modport master (
      output out_data,
      output out_parity_err,
      output out_frame_err,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_parity_err,
      input  out_frame_err,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/glip_uart_receive_cfg.sv
// glip_uart_receive_cfg: configurable UART receiver with FWFT receive buffer.
//   clk_io    : clock
//   rst       : synchronous active-high reset
//   divisor   : clk_io cycles per bit, clamped to a minimum of 4
//   rx        : asynchronous serial input, idle high
//   out       : head-of-buffer data/flags with ready/valid handshake (master modport)
//   level     : current buffer entry count
//   overflow  : sticky, a completed frame was dropped on a full buffer
//   break_det : one-cycle pulse per detected break
module glip_uart_receive_cfg #(
   parameter int unsigned DATA_BITS  = 8,
   parameter string       PARITY     = "NONE",
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned DIV_WIDTH  = 16,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                         clk_io,
   input  logic                         rst,
   input  logic [DIV_WIDTH-1:0]         divisor,
   input  logic                         rx,
   glip_uart_receive_cfg_if.master      out,
   output logic [$clog2(FIFO_DEPTH):0]  level,
   output logic                         overflow,
   output logic                         break_det
);

   localparam int unsigned AW        = $clog2(FIFO_DEPTH);
   localparam int unsigned EW        = DATA_BITS + 2;
   localparam bit          HasParity = (PARITY != "NONE");
   localparam bit          OddParity = (PARITY == "ODD");
   localparam logic [AW:0] DepthCnt  = (AW+1)'(FIFO_DEPTH);

   localparam logic [2:0] StIdle      = 3'd0;
   localparam logic [2:0] StStart     = 3'd1;
   localparam logic [2:0] StData      = 3'd2;
   localparam logic [2:0] StParity    = 3'd3;
   localparam logic [2:0] StStop      = 3'd4;
   localparam logic [2:0] StBreakWait = 3'd5;

   // Input synchroniser
   logic rx_meta, rxs;

   always_ff @(posedge clk_io) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   // Receive FSM
   logic [2:0]           state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 ferr_q, ferr_d;
   logic                 stop_one_q, stop_one_d;

   logic                 tick;
   logic [DIV_WIDTH-1:0] div_sel;
   logic                 ferr_n, stop_one_n;
   logic                 par_x, perr;
   logic                 push, brk;
   logic [EW-1:0]        entry;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      par_d      = par_q;
      ferr_d     = ferr_q;
      stop_one_d = stop_one_q;
      push       = 1'b0;
      brk        = 1'b0;
      tick       = (cnt_q == '0);
      div_sel    = (divisor < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : divisor;
      ferr_n     = ferr_q | ~rxs;
      stop_one_n = stop_one_q | rxs;
      par_x      = (^shift_q) ^ par_q;
      perr       = HasParity && (OddParity ? ~par_x : par_x);
      entry      = {perr, ferr_n, shift_q};

      unique case (state_q)
         StIdle: begin
            if (!rxs) begin
               state_d = StStart;
               div_d   = div_sel;
               // Counting starts the cycle after the edge is seen, so one less than
               // half a bit puts the start sample exactly div/2 cycles after it.
               cnt_d   = (div_sel >> 1) - DIV_WIDTH'(1);
            end
         end

         StStart: begin
            if (!tick) begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end else if (rxs) begin
               state_d = StIdle;
            end else begin
               cnt_d   = div_q - DIV_WIDTH'(1);
               bit_d   = '0;
               state_d = StData;
            end
         end

         StData: begin
            if (!tick) begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end else begin
               cnt_d   = div_q - DIV_WIDTH'(1);
               shift_d = {rxs, shift_q[DATA_BITS-1:1]};
               if (bit_q == 4'(DATA_BITS - 1)) begin
                  bit_d      = '0;
                  ferr_d     = 1'b0;
                  stop_one_d = 1'b0;
                  par_d      = 1'b0;
                  state_d    = HasParity ? StParity : StStop;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end

         StParity: begin
            if (!tick) begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end else begin
               cnt_d   = div_q - DIV_WIDTH'(1);
               par_d   = rxs;
               state_d = StStop;
            end
         end

         StStop: begin
            if (!tick) begin
               cnt_d = cnt_q - DIV_WIDTH'(1);
            end else begin
               cnt_d = div_q - DIV_WIDTH'(1);
               if (bit_q == 4'(STOP_BITS - 1)) begin
                  // Break: every sampled bit after the start bit was low.
                  if ((shift_q == '0) && (!HasParity || !par_q) && !stop_one_n) begin
                     brk     = 1'b1;
                     state_d = StBreakWait;
                  end else begin
                     push    = 1'b1;
                     state_d = StIdle;
                  end
               end else begin
                  bit_d      = bit_q + 4'd1;
                  ferr_d     = ferr_n;
                  stop_one_d = stop_one_n;
               end
            end
         end

         StBreakWait: begin
            if (rxs) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_io) begin
      if (rst) begin
         state_q    <= StBreakWait;
         cnt_q      <= '0;
         div_q      <= DIV_WIDTH'(4);
         bit_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         ferr_q     <= 1'b0;
         stop_one_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         ferr_q     <= ferr_d;
         stop_one_q <= stop_one_d;
      end
   end

   // Receive buffer: entries are {parity_err, frame_err, data}
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_q, rd_q;
   logic [AW:0]   count;
   logic          full, pop, do_push;
   logic [EW-1:0] head;

   assign count   = wr_q - rd_q;
   assign full    = (count == DepthCnt);
   assign pop     = out.out_valid & out.out_ready;
   // Fullness is judged before a same-cycle pop frees a slot.
   assign do_push = push & ~full;
   assign head    = mem[rd_q[AW-1:0]];

   always_ff @(posedge clk_io) begin
      if (rst) begin
         wr_q      <= '0;
         rd_q      <= '0;
         overflow  <= 1'b0;
         break_det <= 1'b0;
      end else begin
         break_det <= brk;
         if (do_push) begin
            wr_q <= wr_q + 1'b1;
         end
         if (pop) begin
            rd_q <= rd_q + 1'b1;
         end
         if (push && full) begin
            overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_io) begin
      if (do_push) begin
         mem[wr_q[AW-1:0]] <= entry;
      end
   end

   always_comb begin
      level              = count;
      out.out_valid      = (count != '0);
      // Outputs read as zero while empty so the reset state is fully defined.
      out.out_data       = out.out_valid ? head[DATA_BITS-1:0] : '0;
      out.out_frame_err  = out.out_valid & head[DATA_BITS];
      out.out_parity_err = out.out_valid & head[DATA_BITS+1];
   end

endmodule

// File: tb/tb_glip_uart_receive_cfg.sv
// tb_glip_uart_receive_cfg: self-checking bench for glip_uart_receive_cfg
// (8 data bits, even parity, 2 stop bits, 16-entry buffer).
module tb_glip_uart_receive_cfg;

   logic        clk_io = 1'b0;
   logic        rst    = 1'b1;
   logic        rx     = 1'b1;
   logic [15:0] divisor = 16'd16;
   logic [4:0]  level;
   logic        overflow;
   logic        break_det;

   int checks  = 0;
   int errors  = 0;
   int brk_cnt = 0;

   glip_uart_receive_cfg_if #(.DATA_BITS(8)) out_if ();

   glip_uart_receive_cfg #(
      .DATA_BITS  (8),
      .PARITY     ("EVEN"),
      .STOP_BITS  (2),
      .DIV_WIDTH  (16),
      .FIFO_DEPTH (16)
   ) dut (
      .clk_io    (clk_io),
      .rst       (rst),
      .divisor   (divisor),
      .rx        (rx),
      .out       (out_if),
      .level     (level),
      .overflow  (overflow),
      .break_det (break_det)
   );

   always #5 clk_io = ~clk_io;

   always @(negedge clk_io) begin
      if (break_det === 1'b1) brk_cnt++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_io);
         #1;
      end
   endtask

   function automatic int bit_cycles();
      return (divisor < 16'd4) ? 4 : int'(divisor);
   endfunction

   // Drives start, 8 data bits LSB first, parity, stop[0], stop[1]; then idles high.
   // rise = cycles from the start edge on the pin until out_valid first rises (-1 if never).
   task automatic send_frame(input logic [7:0] d, input logic p, input logic [1:0] stp,
                             output int rise);
      logic [11:0] f;
      int bc;
      logic was_valid;
      bc = bit_cycles();
      f = {stp[1], stp[0], p, d, 1'b0};
      rise = -1;
      was_valid = out_if.out_valid;
      for (int i = 0; i < 12 * bc; i++) begin
         rx = f[i / bc];
         step(1);
         if (!was_valid && out_if.out_valid === 1'b1 && rise < 0) rise = i + 1;
      end
      rx = 1'b1;
      step(2 * bc + 4);
   endtask

   task automatic pop_head;
      out_if.out_ready = 1'b1;
      step(1);
      out_if.out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      rx = 1'b1;
      out_if.out_ready = 1'b0;
      step(5);
      rst = 1'b0;
      step(1);
      checks++;
      if (level !== 5'd0 || out_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_level: level=%0d valid=%b expected 0/0", level, out_if.out_valid);
      end
      checks++;
      if (overflow !== 1'b0 || break_det !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: overflow=%b break=%b expected 0/0", overflow, break_det);
      end
      checks++;
      if ({out_if.out_parity_err, out_if.out_frame_err, out_if.out_data} !== 10'h000) begin
         errors++;
         $display("FAIL reset_data: got %b/%b/%h expected 0/0/00", out_if.out_parity_err,
                  out_if.out_frame_err, out_if.out_data);
      end
      step(4);
   endtask

   task automatic test_good_frame;
      int rise;
      int bc;
      divisor = 16'd16;
      bc = bit_cycles();
      send_frame(8'hA5, 1'b0, 2'b11, rise);
      checks++;
      if (rise != 2 + bc / 2 + 11 * bc + 1) begin
         errors++;
         $display("FAIL good_timing: valid rose %0d cycles after edge, expected %0d", rise,
                  2 + bc / 2 + 11 * bc + 1);
      end
      checks++;
      if (level !== 5'd1) begin
         errors++;
         $display("FAIL good_level: level=%0d expected 1", level);
      end
      checks++;
      if (out_if.out_data !== 8'hA5 || out_if.out_parity_err !== 1'b0 ||
          out_if.out_frame_err !== 1'b0) begin
         errors++;
         $display("FAIL good_entry: got %h p=%b f=%b expected a5 p=0 f=0", out_if.out_data,
                  out_if.out_parity_err, out_if.out_frame_err);
      end
      pop_head();
      checks++;
      if (out_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL good_pop: valid=%b expected 0", out_if.out_valid);
      end
   endtask

   task automatic test_parity_err;
      int rise;
      send_frame(8'hA5, 1'b1, 2'b11, rise);
      checks++;
      if (out_if.out_valid !== 1'b1 || out_if.out_data !== 8'hA5 ||
          out_if.out_parity_err !== 1'b1 || out_if.out_frame_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_err: valid=%b data=%h p=%b f=%b expected 1 a5 1 0",
                  out_if.out_valid, out_if.out_data, out_if.out_parity_err,
                  out_if.out_frame_err);
      end
      pop_head();
   endtask

   task automatic test_glitch_stop;
      int rise;
      int brk0;
      brk0 = brk_cnt;
      rx = 1'b0;
      step(6);
      rx = 1'b1;
      step(40);
      checks++;
      if (level !== 5'd0 || brk_cnt != brk0) begin
         errors++;
         $display("FAIL glitch: level=%0d breaks=%0d expected 0/0", level, brk_cnt - brk0);
      end
      send_frame(8'h3C, 1'b0, 2'b01, rise);
      checks++;
      if (level !== 5'd1 || out_if.out_data !== 8'h3C || out_if.out_frame_err !== 1'b1 ||
          out_if.out_parity_err !== 1'b0) begin
         errors++;
         $display("FAIL stop_err: level=%0d data=%h f=%b p=%b expected 1 3c 1 0", level,
                  out_if.out_data, out_if.out_frame_err, out_if.out_parity_err);
      end
      pop_head();
   endtask

   task automatic test_break;
      int rise;
      int brk0;
      brk0 = brk_cnt;
      rx = 1'b0;
      step(20 * bit_cycles());
      rx = 1'b1;
      step(40);
      checks++;
      if (brk_cnt - brk0 != 1) begin
         errors++;
         $display("FAIL break_pulse: pulse cycles=%0d expected 1", brk_cnt - brk0);
      end
      checks++;
      if (level !== 5'd0) begin
         errors++;
         $display("FAIL break_level: level=%0d expected 0", level);
      end
      send_frame(8'h55, 1'b0, 2'b11, rise);
      checks++;
      if (level !== 5'd1 || out_if.out_data !== 8'h55 || out_if.out_frame_err !== 1'b0 ||
          out_if.out_parity_err !== 1'b0) begin
         errors++;
         $display("FAIL after_break: level=%0d data=%h f=%b p=%b expected 1 55 0 0", level,
                  out_if.out_data, out_if.out_frame_err, out_if.out_parity_err);
      end
      pop_head();
   endtask

   task automatic test_overflow;
      int rise;
      logic [7:0] v;
      out_if.out_ready = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         v = 8'(i);
         send_frame(v, ^v, 2'b11, rise);
      end
      checks++;
      if (level !== 5'd16 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_state: level=%0d overflow=%b expected 16/1", level, overflow);
      end
      // Drain with ready held high: a new head every cycle.
      out_if.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (out_if.out_valid !== 1'b1 || out_if.out_data !== 8'(i)) begin
            errors++;
            $display("FAIL drain_%0d: valid=%b data=%h expected 1 %h", i, out_if.out_valid,
                     out_if.out_data, 8'(i));
         end
         step(1);
      end
      out_if.out_ready = 1'b0;
      checks++;
      if (out_if.out_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL drain_end: valid=%b level=%0d overflow=%b expected 0 0 1",
                  out_if.out_valid, level, overflow);
      end
   endtask

   task automatic test_reset_mid;
      int rise;
      logic [11:0] f;
      send_frame(8'h11, 1'b0, 2'b11, rise);
      send_frame(8'h22, 1'b0, 2'b11, rise);
      send_frame(8'h33, 1'b0, 2'b11, rise);
      checks++;
      if (level !== 5'd3) begin
         errors++;
         $display("FAIL pre_reset_level: level=%0d expected 3", level);
      end
      f = {2'b11, 1'b0, 8'h0F, 1'b0};
      for (int i = 0; i < 60; i++) begin
         rx = f[i / 16];
         step(1);
      end
      rst = 1'b1;
      rx = 1'b1;
      step(1);
      checks++;
      if (level !== 5'd0 || out_if.out_valid !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: level=%0d valid=%b overflow=%b expected 0 0 0", level,
                  out_if.out_valid, overflow);
      end
      rst = 1'b0;
      step(300);
      checks++;
      if (level !== 5'd0) begin
         errors++;
         $display("FAIL post_reset_idle: level=%0d expected 0", level);
      end
   endtask

   task automatic test_rx_low_reset;
      int rise;
      rx = 1'b0;
      rst = 1'b1;
      step(4);
      rst = 1'b0;
      step(250);
      checks++;
      if (level !== 5'd0 || out_if.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL low_through_reset: level=%0d valid=%b expected 0/0", level,
                  out_if.out_valid);
      end
      rx = 1'b1;
      step(10);
      send_frame(8'h5A, 1'b0, 2'b11, rise);
      checks++;
      if (level !== 5'd1 || out_if.out_data !== 8'h5A || out_if.out_frame_err !== 1'b0 ||
          out_if.out_parity_err !== 1'b0) begin
         errors++;
         $display("FAIL fresh_frame: level=%0d data=%h f=%b p=%b expected 1 5a 0 0", level,
                  out_if.out_data, out_if.out_frame_err, out_if.out_parity_err);
      end
      pop_head();
   endtask

   // Random frames at random divisors against a queue model of the buffer.
   task automatic test_random;
      logic [9:0] exp_q[$];
      logic [9:0] e;
      logic [7:0] d;
      logic       p;
      logic [1:0] stp;
      logic       pe, fe;
      int rise;
      int n;
      int brk0;
      int exp_brk;
      for (int r = 0; r < 4; r++) begin
         case ($urandom % 5)
            0: divisor = 16'd3;
            1: divisor = 16'd4;
            2: divisor = 16'd7;
            3: divisor = 16'd16;
            default: divisor = 16'd23;
         endcase
         brk0 = brk_cnt;
         exp_brk = 0;
         n = $urandom_range(4, 10);
         for (int k = 0; k < n; k++) begin
            d = 8'($urandom);
            p = (^d) ^ (($urandom % 4) == 0);
            stp = (($urandom % 3) == 0) ? 2'($urandom) : 2'b11;
            if (($urandom % 8) == 0) begin
               d = 8'h00;
               p = 1'b0;
               stp = 2'b00;
            end
            if (d == 8'h00 && p == 1'b0 && stp == 2'b00) begin
               exp_brk++;
            end else if (exp_q.size() < 16) begin
               pe = (^d) ^ p;
               fe = (stp != 2'b11);
               exp_q.push_back({pe, fe, d});
            end
            send_frame(d, p, stp, rise);
         end
         checks++;
         if (int'(level) != exp_q.size() || brk_cnt - brk0 != exp_brk) begin
            errors++;
            $display("FAIL rand_level_%0d: level=%0d breaks=%0d expected %0d %0d", r, level,
                     brk_cnt - brk0, exp_q.size(), exp_brk);
         end
         for (int k = 0; k < 16 && exp_q.size() > 0; k++) begin
            e = exp_q.pop_front();
            checks++;
            if (out_if.out_valid !== 1'b1 ||
                {out_if.out_parity_err, out_if.out_frame_err, out_if.out_data} !== e) begin
               errors++;
               $display("FAIL rand_entry_%0d_%0d: valid=%b p/f/data=%b/%b/%h expected %b/%b/%h",
                        r, k, out_if.out_valid, out_if.out_parity_err, out_if.out_frame_err,
                        out_if.out_data, e[9], e[8], e[7:0]);
            end
            pop_head();
         end
         checks++;
         if (out_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_empty_%0d: valid=%b expected 0", r, out_if.out_valid);
         end
      end
      divisor = 16'd16;
   endtask

   initial begin
      out_if.out_ready = 1'b0;
      test_reset();
      test_good_frame();
      test_parity_err();
      test_glitch_stop();
      test_break();
      test_overflow();
      test_reset_mid();
      test_rx_low_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3ms;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "time limit");
   end

endmodule
